ifetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents {pc, instr, opcode, func3} to the decode stage with valid/ready.
- Accepts branch/jump redirects from execute, which flush the buffer and discard any in-flight response.

---
 rtl/ifetch_queue.sv | 109 ++++++++++
 tb/tb_ifetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues word requests over req/gnt/rvalid, buffers
// returned words in a small FIFO and hands {pc, instr} to decode with valid/ready.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [6:0]  id_opcode,
   output logic [2:0]  id_func3
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DROP = 2'd3;

   logic [1:0]    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign push = (state == WAIT) && imem_rvalid && !redirect_valid;
   assign pop  = (count != '0) && id_ready;

   // Redirect outranks everything: it retargets fetch, empties the FIFO and
   // turns any granted-but-unanswered request into one whose data is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         case (state)
            REQ:     state <= imem_gnt ? DROP : IDLE;
            WAIT:    state <= imem_rvalid ? IDLE : DROP;
            DROP:    state <= imem_rvalid ? IDLE : DROP;
            default: state <= IDLE;
         endcase
      end else begin
         case (state)
            IDLE: if (count < FULL) state <= REQ;
            REQ: begin
               if (imem_gnt) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 32'd4;
                  state    <= WAIT;
               end
            end
            WAIT:    if (imem_rvalid) state <= IDLE;
            default: if (imem_rvalid) state <= IDLE;
         endcase
         if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign imem_req  = (state == REQ);
   assign imem_addr = fetch_pc;
   assign id_valid  = (count != '0);
   assign id_instr  = instr_mem[rd_ptr];
   assign id_pc     = pc_mem[rd_ptr];
   assign id_opcode = id_instr[6:0];
   assign id_func3  = id_instr[14:12];

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level reference model.
module tb_ifetch_queue;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  id_opcode;
   logic [2:0]  id_func3;

   int errors = 0;
   int checks = 0;

   // Reference model: expected fetch PC, outstanding-request bookkeeping and
   // the queue of instructions decode should see, in order.
   entry_t      q[$];
   logic [31:0] mPc;
   logic [31:0] mReqPc;
   bit          mReq;
   bit          mBusy;
   bit          mStale;
   bit          mJustReset;

   // Memory responder state and directed-test knobs.
   bit          memPending = 1'b0;
   int          memDelay   = 0;
   int          fixedDelay = -1;
   bit          useForce   = 1'b0;
   logic [31:0] forceData  = '0;

   always #5 clk = ~clk;

   ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_opcode(id_opcode), .id_func3(id_func3)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("id_valid", {31'b0, id_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
         checkOutput("id_pc", id_pc, q[0].pc);
         checkOutput("id_instr", id_instr, q[0].instr);
         checkOutput("id_opcode", {25'b0, id_opcode}, {25'b0, q[0].instr[6:0]});
         checkOutput("id_func3", {29'b0, id_func3}, {29'b0, q[0].instr[14:12]});
      end
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, mReq});
      if (mReq) checkOutput("imem_addr", imem_addr, mPc);
      if (mJustReset) begin
         checkOutput("reset_id_pc", id_pc, 32'h0);
         checkOutput("reset_id_instr", id_instr, 32'h0);
      end
   endtask

   // One clock cycle: drive inputs, advance memory and model, then check.
   task automatic applyStimulus(input bit rst, input bit gntEn, input bit redir,
                                input logic [31:0] rpc, input bit ready);
      logic        g;
      logic        rv;
      logic [31:0] data;
      bit          issue;
      entry_t      e;
      rv   = memPending && (memDelay == 0);
      data = useForce ? forceData : $urandom;
      g    = imem_req && gntEn && !memPending;
      rst_n          = rst;
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = data;
      redirect_valid = redir;
      redirect_pc    = rpc;
      id_ready       = ready;

      if (rv) memPending = 1'b0;
      else if (memPending) memDelay--;
      if (g) begin
         memPending = 1'b1;
         memDelay   = (fixedDelay > 0) ? fixedDelay - 1 : int'($urandom_range(0, 2));
      end

      mJustReset = 1'b0;
      if (!rst) begin
         q.delete();
         mPc = RESET_PC; mReq = 1'b0; mBusy = 1'b0; mStale = 1'b0;
         mJustReset = 1'b1;
      end else if (redir) begin
         q.delete();
         mPc = {rpc[31:2], 2'b00};
         if (mReq) begin
            mReq = 1'b0;
            if (g) begin mBusy = 1'b1; mStale = 1'b1; end
         end else if (mBusy && rv) mBusy = 1'b0;
         else if (mBusy) mStale = 1'b1;
      end else begin
         issue = !mReq && !mBusy && (q.size() < DEPTH);
         if (ready && q.size() > 0) void'(q.pop_front());
         if (mReq && g) begin
            mReqPc = mPc; mPc = mPc + 32'd4;
            mReq = 1'b0; mBusy = 1'b1; mStale = 1'b0;
         end else if (mBusy && rv) begin
            if (!mStale) begin e.pc = mReqPc; e.instr = data; q.push_back(e); end
            mBusy = 1'b0;
         end else if (issue) mReq = 1'b1;
      end

      @(posedge clk);
      #1;
      compareAll();
   endtask

   task automatic waitInFlight(input string tag);
      int n = 0;
      while (!(mBusy && !mStale) && n < 30) begin
         applyStimulus(1, 1, 0, 0, 1);
         n++;
      end
      checkOutput({tag, "_reached_wait"}, {31'b0, mBusy && !mStale}, 32'h1);
   endtask

   initial begin
      int n;
      rst_n = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      redirect_valid = 0; redirect_pc = 0; id_ready = 0;
      #1;
      repeat (2) applyStimulus(0, 0, 0, 0, 0);

      // Streaming with an immediate grant and a one-cycle response.
      fixedDelay = 1; useForce = 1; forceData = 32'h0050_0093;
      repeat (14) applyStimulus(1, 1, 0, 0, 1);
      checkOutput("pc_advanced", {31'b0, mPc > RESET_PC + 32'd8}, 32'h1);

      // Decode stalled: queue fills to DEPTH, then drains in order.
      useForce = 0;
      repeat (14) applyStimulus(1, 1, 0, 0, 0);
      checkOutput("fifo_full", q.size(), DEPTH);
      repeat (10) applyStimulus(1, 1, 0, 0, 1);

      // Redirect while waiting; the late word must never be presented.
      fixedDelay = 2; useForce = 1; forceData = 32'hDEAD_BEEF;
      waitInFlight("redir_wait");
      applyStimulus(1, 1, 1, 32'h0040_0103, 1);
      useForce = 0;
      repeat (10) applyStimulus(1, 1, 0, 0, 1);

      // Redirect in the same cycle as a pop from a full queue.
      fixedDelay = -1;
      n = 0;
      while (q.size() < DEPTH && n < 40) begin applyStimulus(1, 1, 0, 0, 0); n++; end
      checkOutput("refill_full", q.size(), DEPTH);
      applyStimulus(1, 1, 1, 32'h0040_0200, 1);
      repeat (8) applyStimulus(1, 1, 0, 0, 1);

      // Fetch PC wrap-around at the top of the address space.
      applyStimulus(1, 1, 1, 32'hFFFF_FFFC, 1);
      repeat (10) applyStimulus(1, 1, 0, 0, 1);

      // Reset while a response is outstanding; it arrives after release.
      fixedDelay = 3;
      waitInFlight("reset_wait");
      applyStimulus(0, 1, 0, 0, 1);
      fixedDelay = -1;
      repeat (12) applyStimulus(1, 1, 0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 99) < 6), $urandom, ($urandom_range(0, 9) < 6));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
